// File: rtl/cla_wide_add_seq.sv
// cla_wide_add_seq
//   Multi-precision adder sequencer. Feeds one 32-bit word pair per clock,
//   least significant word first, into a single 32-bit recursive-doubling
//   CLA. The CLA carry-out is chained through a register into the next
//   word's iniC. When the top word finishes, it reports the W-bit sum,
//   the carry-out and the two's-complement overflow.
//
//   Parameter
//     WORDS    number of 32-bit words per operand (>=1); W = 32*WORDS
//
//   Ports
//     clk      rising-edge clock
//     rst      synchronous active-high reset; has priority over all inputs
//     start    operation request; sampled only when idle
//     a_in     operand A (W bits); captured on the accepting edge
//     b_in     operand B (W bits); captured on the accepting edge
//     cin      carry into word 0; captured on the accepting edge
//     busy     high while an operation is in progress
//     done     one-cycle pulse when sum_out/cout/ovf are newly valid
//     sum_out  (a+b+cin) mod 2^W
//     cout     carry out of bit W-1
//     ovf      signed overflow of the W-bit add
//
// CLA
//   32-bit recursive-doubling (Kogge-Stone) carry-lookahead adder.
//     A, B   addends
//     iniC   carry in
//     Sum    A+B+iniC, low 32 bits
//     Carry  carry out of bit 31

module CLA (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        iniC,
  output logic [31:0] Sum,
  output logic        Carry
);
  logic [31:0] w_p;
  logic [31:0] w_g;
  logic [31:0] w_gg;
  logic [31:0] w_pp;
  logic [31:0] w_gt;
  logic [31:0] w_pt;

  assign w_p = A ^ B;
  assign w_g = A & B;

  // Carry-in is folded into bit 0's generate, so after the prefix pass
  // w_gg[i] is the carry out of bit i.
  always_comb begin
    w_gg    = w_g;
    w_pp    = w_p;
    w_gg[0] = w_g[0] | (w_p[0] & iniC);
    w_gt    = '0;
    w_pt    = '0;
    for (int lv = 0; lv < 5; lv++) begin
      w_gt = w_gg;
      w_pt = w_pp;
      for (int i = (1 << lv); i < 32; i++) begin
        w_gg[i] = w_gt[i] | (w_pt[i] & w_gt[i - (1 << lv)]);
        w_pp[i] = w_pt[i] & w_pt[i - (1 << lv)];
      end
    end
  end

  assign Sum   = w_p ^ {w_gg[30:0], iniC};
  assign Carry = w_gg[31];
endmodule

module cla_wide_add_seq #(
  parameter int WORDS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [32*WORDS-1:0] a_in,
  input  logic [32*WORDS-1:0] b_in,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [32*WORDS-1:0] sum_out,
  output logic                cout,
  output logic                ovf
);
  localparam int W  = 32 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IW-1:0]   r_index;
  logic            r_busy;
  logic            r_done;
  logic            r_cout;
  logic            r_ovf;

  logic [31:0]     w_a_words [WORDS];
  logic [31:0]     w_b_words [WORDS];
  logic [31:0]     w_cla_a;
  logic [31:0]     w_cla_b;
  logic [31:0]     w_cla_sum;
  logic            w_cla_carry;
  logic            w_run;
  logic            w_last;

  // Split the latched operands into 32-bit words for the per-word mux.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_split
      assign w_a_words[gi] = r_a[gi*32 +: 32];
      assign w_b_words[gi] = r_b[gi*32 +: 32];
    end

    if (WORDS == 1) begin : g_mux_single
      assign w_cla_a = w_a_words[0];
      assign w_cla_b = w_b_words[0];
    end else begin : g_mux_multi
      assign w_cla_a = w_a_words[r_index];
      assign w_cla_b = w_b_words[r_index];
    end
  endgenerate

  CLA u_cla (
    .A     (w_cla_a),
    .B     (w_cla_b),
    .iniC  (r_carry),
    .Sum   (w_cla_sum),
    .Carry (w_cla_carry)
  );

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_index == LAST);

  // Each result word is its own register, written when the sequencer
  // is on that word.
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_sum
      logic [31:0] r_word;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_word <= '0;
        end else if (w_run && (r_index == IW'(gi))) begin
          r_word <= w_cla_sum;
        end
      end
      assign sum_out[gi*32 +: 32] = r_word;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_index <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_carry <= cin;
            r_index <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_carry <= w_cla_carry;
          if (w_last) begin
            // Overflow: operands agree in sign but the result does not.
            r_cout  <= w_cla_carry;
            r_ovf   <= (r_a[W-1] == r_b[W-1]) & (w_cla_sum[31] != r_a[W-1]);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_index <= '0;
            r_state <= S_IDLE;
          end else begin
            r_index <= r_index + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule
